// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift per clock.
// Optional invalid-digit check enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   BCD,
    output logic [BIN_W-1:0]      BIN,
    output logic                  BUSY,
    output logic                  VALID,
    output logic                  ERR
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BW + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q;
    logic [BW-1:0]      digit_q;
    logic [BW-1:0]      bin_q;
    logic [CW-1:0]      cnt_q;
    logic [BIN_W-1:0]   bin_o_q;
    logic               busy_q;
    logic               valid_q;

    logic [2*BW-1:0]    shifted;
    logic [BW-1:0]      digit_d;
    logic [BIN_W-1:0]   bin_ext;

    assign shifted = {digit_q, bin_q} >> 1;

    // Per-nibble correction after the shift; nibbles never borrow from each other.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign digit_d[4*gi +: 4] = shifted[BW + 4*gi + 3]
                                      ? shifted[BW + 4*gi +: 4] - 4'd3
                                      : shifted[BW + 4*gi +: 4];
        end
    endgenerate

    generate
        if (BIN_W > BW) begin : g_ext_wide
            assign bin_ext = {{(BIN_W - BW){1'b0}}, bin_q};
        end else if (BIN_W == BW) begin : g_ext_eq
            assign bin_ext = bin_q;
        end else begin : g_ext_narrow
            assign bin_ext = bin_q[BIN_W-1:0];
        end
    endgenerate

`ifdef BCD_DIGIT_CHECK_EN
    logic [DIGITS-1:0]  bad_v;
    logic               err_q;
    logic               err_pend_q;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign bad_v[gi] = (BCD[4*gi +: 4] > 4'd9);
        end
    endgenerate
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            digit_q    <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            bin_o_q    <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        digit_q <= BCD;
                        bin_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                        err_q <= 1'b0;
                        if (|bad_v) begin
                            err_pend_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            err_pend_q <= 1'b0;
                            state_q    <= SHIFT;
                        end
`else
                        state_q <= SHIFT;
`endif
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    digit_q <= digit_d;
                    bin_q   <= shifted[BW-1:0];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(BW - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // BUSY stays high through the next edge, where a new START may be taken.
                    valid_q <= 1'b1;
                    state_q <= IDLE;
`ifdef BCD_DIGIT_CHECK_EN
                    if (err_pend_q) begin
                        err_q <= 1'b1;
                    end else begin
                        bin_o_q <= bin_ext;
                    end
`else
                    bin_o_q <= bin_ext;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BIN   = bin_o_q;
    assign BUSY  = busy_q;
    assign VALID = valid_q;
`ifdef BCD_DIGIT_CHECK_EN
    assign ERR   = err_q;
`else
    assign ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin with hand-computed expected values.
// Error-path vectors run only when BCD_DIGIT_CHECK_EN is defined.
module tb_bcd_to_bin;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] BCD = 16'h0000;
    logic [15:0] BIN;
    logic        BUSY;
    logic        VALID;
    logic        ERR;

    int n_vec = 0;
    int n_err = 0;
    int k;
    int pulses;

    bcd_to_bin #(.DIGITS(4), .BIN_W(16)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .BCD   (BCD),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .VALID (VALID),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advances until VALID is seen; returns the number of edges taken (or 99 on timeout).
    task automatic wait_valid(output int edges);
        edges = 99;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (VALID === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (VALID === 1'b1) n++;
        end
    endtask

    initial begin
        tick();
        tick();
        RST = 1'b0;
        chk("rst_bin", 32'(BIN), 32'h0000);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_valid", 32'(VALID), 32'h0);
        chk("rst_err", 32'(ERR), 32'h0);
        $display("reset released");

        // 1234 -> 04D2
        BCD = 16'h1234; START = 1'b1;
        tick();
        START = 1'b0;
        chk("t1_busy", 32'(BUSY), 32'h1);
        wait_valid(k);
        chk("t1_lat", 32'(k), 32'd17);
        chk("t1_bin", 32'(BIN), 32'h04D2);
        chk("t1_err", 32'(ERR), 32'h0);
        chk("t1_busy_v", 32'(BUSY), 32'h1);
        tick();
        chk("t1_valid_end", 32'(VALID), 32'h0);
        chk("t1_busy_end", 32'(BUSY), 32'h0);
        $display("bcd=1234 bin=%h lat=%0d", BIN, k);

        // 9999 then 0000 back-to-back
        BCD = 16'h9999; START = 1'b1;
        tick();
        START = 1'b0;
        wait_valid(k);
        chk("t2a_lat", 32'(k), 32'd17);
        chk("t2a_bin", 32'(BIN), 32'h270F);
        $display("bcd=9999 bin=%h lat=%0d", BIN, k);
        BCD = 16'h0000; START = 1'b1;
        tick();
        START = 1'b0;
        chk("t2b_busy", 32'(BUSY), 32'h1);
        chk("t2b_valid", 32'(VALID), 32'h0);
        wait_valid(k);
        chk("t2b_lat", 32'(k), 32'd17);
        chk("t2b_bin", 32'(BIN), 32'h0000);
        tick();
        chk("t2b_busy_end", 32'(BUSY), 32'h0);
        $display("bcd=0000 bin=%h lat=%0d", BIN, k);

        // 0042 with a second START at N+5 that must be ignored
        BCD = 16'h0042; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (4) tick();
        BCD = 16'h0777; START = 1'b1;
        tick();
        START = 1'b0;
        wait_valid(k);
        chk("t3_lat", 32'(k), 32'd12);
        chk("t3_bin", 32'(BIN), 32'h002A);
        count_pulses(25, pulses);
        chk("t3_extra_valid", 32'(pulses), 32'd0);
        chk("t3_bin_hold", 32'(BIN), 32'h002A);
        $display("bcd=0042 bin=%h lat=%0d extra=%0d", BIN, k, pulses);

        // 5678 aborted by reset at N+8
        BCD = 16'h5678; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (7) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t4_bin", 32'(BIN), 32'h0000);
        chk("t4_busy", 32'(BUSY), 32'h0);
        chk("t4_valid", 32'(VALID), 32'h0);
        count_pulses(20, pulses);
        chk("t4_no_valid", 32'(pulses), 32'd0);
        BCD = 16'h0001; START = 1'b1;
        tick();
        START = 1'b0;
        wait_valid(k);
        chk("t4_lat", 32'(k), 32'd17);
        chk("t4_bin1", 32'(BIN), 32'h0001);
        tick();
        $display("reset abort, then bcd=0001 bin=%h lat=%0d", BIN, k);

`ifdef BCD_DIGIT_CHECK_EN
        BCD = 16'h1234; START = 1'b1;
        tick();
        START = 1'b0;
        wait_valid(k);
        chk("t5_pre_bin", 32'(BIN), 32'h04D2);
        tick();
        BCD = 16'h12A4; START = 1'b1;
        tick();
        START = 1'b0;
        chk("t5_err_n", 32'(ERR), 32'h0);
        chk("t5_valid_n", 32'(VALID), 32'h0);
        tick();
        chk("t5_err", 32'(ERR), 32'h1);
        chk("t5_valid", 32'(VALID), 32'h1);
        chk("t5_bin_keep", 32'(BIN), 32'h04D2);
        tick();
        chk("t5_valid_end", 32'(VALID), 32'h0);
        chk("t5_err_hold", 32'(ERR), 32'h1);
        chk("t5_busy_end", 32'(BUSY), 32'h0);
        $display("bcd=12A4 err=%b bin=%h", ERR, BIN);
        BCD = 16'h0010; START = 1'b1;
        tick();
        START = 1'b0;
        chk("t5_err_clr", 32'(ERR), 32'h0);
        wait_valid(k);
        chk("t5_lat", 32'(k), 32'd17);
        chk("t5_bin", 32'(BIN), 32'h000A);
        chk("t5_err_ok", 32'(ERR), 32'h0);
        tick();
        $display("bcd=0010 bin=%h err=%b", BIN, ERR);
`else
        // Invalid digits still complete with normal latency and no error flag.
        BCD = 16'h00AB; START = 1'b1;
        tick();
        START = 1'b0;
        wait_valid(k);
        chk("t5_lat", 32'(k), 32'd17);
        chk("t5_err0", 32'(ERR), 32'h0);
        tick();
        chk("t5_busy_end", 32'(BUSY), 32'h0);
        $display("bcd=00AB completed lat=%0d err=%b", k, ERR);
`endif

        // START held high: restart every 18 cycles
        BCD = 16'h0250; START = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            wait_valid(k);
            chk($sformatf("t6_lat%0d", r), 32'(k), 32'd17);
            chk($sformatf("t6_bin%0d", r), 32'(BIN), 32'h00FA);
            chk($sformatf("t6_busy%0d", r), 32'(BUSY), 32'h1);
            $display("held start run %0d bin=%h lat=%0d", r, BIN, k);
            if (r < 2) tick();
        end
        START = 1'b0;
        tick();
        tick();
        chk("t6_busy_end", 32'(BUSY), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
